// File: rtl/vec_norm_pkg.sv
// Shared types and width helpers for the sequential vector normalizer.
// Latency: n/a (package only).
// Backpressure: n/a.
package vec_norm_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ACCUM = 3'd1,
      SQRT  = 3'd2,
      DIV   = 3'd3,
      OUT   = 3'd4
   } vn_state_t;

   // Sum-of-squares width: NUM_CH squares of DATAWIDTH-bit values cannot overflow.
   function automatic int vn_sw(input int dw, input int num_ch);
      return 2 * dw + $clog2(num_ch);
   endfunction

   // Output width: unsigned 1.FRAC_BITS so that exactly 1.0 is representable.
   function automatic int vn_qw(input int frac_bits);
      return frac_bits + 1;
   endfunction

   // One root bit per iteration, two radicand bits consumed per iteration.
   function automatic int vn_sq_it(input int sw);
      return (sw + 1) / 2;
   endfunction

   // One quotient bit per dividend bit.
   function automatic int vn_div_it(input int dw, input int frac_bits);
      return dw + frac_bits;
   endfunction

endpackage

// File: rtl/vec_normalizer_seq_serial_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, optional round-half-up.
// Latency: DDW cycles from the start edge; done_o is high during the final iteration.
// Backpressure: none; start_i is ignored while busy_o is high.
//
// Ports: clk, rst_n (async active-low); start_i loads dividend_i/divisor_i;
//        busy_o while iterating; done_o marks the final iteration, and quo_o
//        (low QOW bits of the quotient) is valid in that same cycle only.
module serial_divider #(
   parameter int DDW      = 16,
   parameter int DSW      = 9,
   parameter int QOW      = 9,
   parameter bit ROUND_EN = 1'b0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start_i,
   input  logic [DDW-1:0] dividend_i,
   input  logic [DSW-1:0] divisor_i,
   output logic           busy_o,
   output logic           done_o,
   output logic [QOW-1:0] quo_o
);

   localparam int CNTW = (DDW > 1) ? $clog2(DDW) : 1;

   // The dividend register shifts left each cycle; quotient bits fill in from the LSB.
   logic [DDW-1:0]  dvd_q;
   logic [DSW-1:0]  rem_q;
   logic [DSW-1:0]  dsr_q;
   logic [CNTW-1:0] cnt_q;
   logic            busy_q;

   logic [DSW:0]    rem_t;
   logic            ge;
   logic [DSW-1:0]  rem_nx;
   logic [DDW-1:0]  quo_nx;
   logic [QOW-1:0]  q_trunc;

   assign rem_t   = {rem_q, dvd_q[DDW-1]};
   assign ge      = rem_t >= {1'b0, dsr_q};
   // rem stays below the divisor, so the difference always fits DSW bits.
   assign rem_nx  = DSW'(ge ? rem_t - {1'b0, dsr_q} : rem_t);
   assign quo_nx  = {dvd_q[DDW-2:0], ge};
   assign q_trunc = quo_nx[QOW-1:0];

   assign busy_o = busy_q;
   assign done_o = busy_q && (cnt_q == CNTW'(DDW - 1));

   generate
      if (ROUND_EN) begin : g_round
         logic up;
         assign up    = {rem_nx, 1'b0} >= {1'b0, dsr_q};
         // Hold at all-ones rather than wrap; callers clamp to their own range.
         assign quo_o = (&q_trunc) ? q_trunc : q_trunc + QOW'(up);
      end else begin : g_trunc
         assign quo_o = q_trunc;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_q  <= '0;
         rem_q  <= '0;
         dsr_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start_i && !busy_q) begin
         dvd_q  <= dividend_i;
         rem_q  <= '0;
         dsr_q  <= divisor_i;
         cnt_q  <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         dvd_q <= quo_nx;
         rem_q <= rem_nx;
         cnt_q <= cnt_q + 1'b1;
         if (done_o) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/vec_normalizer_seq.sv
// Normalizes an unsigned NUM_CH vector by floor(sqrt(sum x^2)) with one MAC, serial sqrt and serial divide.
// Latency: first beat NUM_CH+SQ_IT+DIV_IT edges after accept, DIV_IT per later beat; zero vector NUM_CH then 1/beat.
// Backpressure: out beats held until out_ready; in_ready only in IDLE, so vectors never overlap.
//
// Ports: clk; rst (async active-low); in_valid/in_ready/in_data (element i at
//        [i*DATAWIDTH +: DATAWIDTH]); out_valid/out_ready; out_data (1.FRAC_BITS);
//        out_ch (element index); out_last (final beat); out_zero (all-zero vector).
// Build option: define VEC_NORM_ROUND_EN to round the quotient half-up (saturated
//        at 1.0) instead of truncating.
module vec_normalizer_seq
   import vec_norm_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int FRAC_BITS = 8,
   parameter int NUM_CH    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NUM_CH*DATAWIDTH-1:0]   in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [FRAC_BITS:0]            out_data,
   output logic [$clog2(NUM_CH)-1:0]     out_ch,
   output logic                          out_last,
   output logic                          out_zero
);

   localparam int CW     = $clog2(NUM_CH);
   localparam int SW     = vn_sw(DATAWIDTH, NUM_CH);
   localparam int QW     = vn_qw(FRAC_BITS);
   localparam int SQ_IT  = vn_sq_it(SW);
   localparam int DIV_IT = vn_div_it(DATAWIDTH, FRAC_BITS);
   localparam int OPW    = 2 * SQ_IT;     // radicand padded to whole bit pairs
   localparam int RS     = SQ_IT + 1;     // sqrt remainder never exceeds 2*root
   localparam int SQCW   = $clog2(SQ_IT);

   localparam logic [CW-1:0] CH_LAST = CW'(NUM_CH - 1);
   localparam logic [QW-1:0] Q_ONE   = {1'b1, {FRAC_BITS{1'b0}}};

`ifdef VEC_NORM_ROUND_EN
   localparam bit ROUND_EN = 1'b1;
`else
   localparam bit ROUND_EN = 1'b0;
`endif

   vn_state_t state_q, state_d;
   logic [NUM_CH*DATAWIDTH-1:0] x_q, x_d;
   logic [SW-1:0]    acc_q, acc_d;
   logic [OPW-1:0]   op_q, op_d;
   logic [RS-1:0]    srem_q, srem_d;
   logic [SQ_IT-1:0] root_q, root_d;
   logic [SQCW-1:0]  sq_cnt_q, sq_cnt_d;
   logic [CW-1:0]    ch_q, ch_d;
   logic [QW-1:0]    out_data_q, out_data_d;
   logic             out_last_q, out_last_d;
   logic             out_zero_q, out_zero_d;

   logic [DATAWIDTH-1:0]   xe;
   logic [2*DATAWIDTH-1:0] x_sq;
   logic [SW-1:0]          acc_sum;
   logic [CW-1:0]          ch_inc;
   logic [RS+1:0]          sq_rem_t;
   logic [RS+1:0]          sq_trial;
   logic                   sq_ge;
   logic                   div_go;
   logic                   div_start;
   logic                   div_busy;
   logic                   div_done;
   logic [DIV_IT-1:0]      div_dvd;
   logic [QW-1:0]          div_quo;
   logic [QW-1:0]          q_fin;

   // Shared MAC: one element squared and accumulated per ACCUM cycle.
   assign xe      = x_q[int'(ch_q)*DATAWIDTH +: DATAWIDTH];
   assign x_sq    = (2*DATAWIDTH)'(xe) * (2*DATAWIDTH)'(xe);
   assign acc_sum = acc_q + SW'(x_sq);
   assign ch_inc  = ch_q + 1'b1;

   // Restoring sqrt step: bring down two radicand bits, try subtracting 4*root+1.
   assign sq_rem_t = {srem_q, op_q[OPW-1 -: 2]};
   assign sq_trial = {1'b0, root_q, 2'b01};
   assign sq_ge    = sq_rem_t >= sq_trial;

   // The divide is loaded on the edge that enters DIV, so it takes the channel
   // and root being written on that same edge.
   assign div_dvd   = {x_q[int'(ch_d)*DATAWIDTH +: DATAWIDTH], {FRAC_BITS{1'b0}}};
   assign div_start = div_go && !div_busy;

   serial_divider #(
      .DDW      (DIV_IT),
      .DSW      (SQ_IT),
      .QOW      (QW),
      .ROUND_EN (ROUND_EN)
   ) u_div (
      .clk        (clk),
      .rst_n      (rst),
      .start_i    (div_start),
      .dividend_i (div_dvd),
      .divisor_i  (root_d),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quo_o      (div_quo)
   );

   // x never exceeds root, so the truncated quotient is already <= 1.0;
   // only the rounding increment can step past it.
`ifdef VEC_NORM_ROUND_EN
   assign q_fin = (div_quo > Q_ONE) ? Q_ONE : div_quo;
`else
   assign q_fin = div_quo;
`endif

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      acc_d      = acc_q;
      op_d       = op_q;
      srem_d     = srem_q;
      root_d     = root_q;
      sq_cnt_d   = sq_cnt_q;
      ch_d       = ch_q;
      out_data_d = out_data_q;
      out_last_d = out_last_q;
      out_zero_d = out_zero_q;
      div_go     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               x_d        = in_data;
               acc_d      = '0;
               ch_d       = '0;
               out_data_d = '0;
               out_last_d = 1'b0;
               out_zero_d = 1'b0;
               state_d    = ACCUM;
            end
         end
         ACCUM: begin
            acc_d = acc_sum;
            if (ch_q == CH_LAST) begin
               ch_d = '0;
               if (acc_sum == '0) begin
                  // Nothing to normalise: stream zeros straight away.
                  out_zero_d = 1'b1;
                  state_d    = OUT;
               end else begin
                  op_d     = OPW'(acc_sum);
                  srem_d   = '0;
                  root_d   = '0;
                  sq_cnt_d = '0;
                  state_d  = SQRT;
               end
            end else begin
               ch_d = ch_inc;
            end
         end
         SQRT: begin
            srem_d   = RS'(sq_ge ? sq_rem_t - sq_trial : sq_rem_t);
            root_d   = {root_q[SQ_IT-2:0], sq_ge};
            op_d     = {op_q[OPW-3:0], 2'b00};
            sq_cnt_d = sq_cnt_q + 1'b1;
            if (sq_cnt_q == SQCW'(SQ_IT - 1)) begin
               div_go  = 1'b1;
               state_d = DIV;
            end
         end
         DIV: begin
            if (div_done) begin
               out_data_d = q_fin;
               out_last_d = (ch_q == CH_LAST);
               state_d    = OUT;
            end
         end
         OUT: begin
            if (out_ready) begin
               if (ch_q == CH_LAST) begin
                  state_d = IDLE;
               end else begin
                  ch_d = ch_inc;
                  if (out_zero_q) begin
                     out_last_d = (ch_inc == CH_LAST);
                  end else begin
                     div_go  = 1'b1;
                     state_d = DIV;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         x_q        <= '0;
         acc_q      <= '0;
         op_q       <= '0;
         srem_q     <= '0;
         root_q     <= '0;
         sq_cnt_q   <= '0;
         ch_q       <= '0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
         out_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         acc_q      <= acc_d;
         op_q       <= op_d;
         srem_q     <= srem_d;
         root_q     <= root_d;
         sq_cnt_q   <= sq_cnt_d;
         ch_q       <= ch_d;
         out_data_q <= out_data_d;
         out_last_q <= out_last_d;
         out_zero_q <= out_zero_d;
      end
   end

   // in_ready is masked by rst so it reads 0 for the whole reset pulse.
   assign in_ready  = (state_q == IDLE) && rst;
   assign out_valid = (state_q == OUT);
   assign out_data  = out_data_q;
   assign out_ch    = ch_q;
   assign out_last  = out_last_q;
   assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_vec_normalizer_seq.sv
module tb_vec_normalizer_seq;

   localparam int NCH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [8:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_last;
   logic        out_zero;

   int ntot = 0;
   int nbad = 0;
   int cyc  = 0;
   int t_acc;
   bit snd_to;

   logic [8:0] cap_data [NCH];
   logic [1:0] cap_ch   [NCH];
   logic       cap_last [NCH];
   logic       cap_zero [NCH];
   int         cap_rise [NCH];
   bit         cap_unstable, cap_inrdy_bad, cap_timeout;
   int         cap_last_hs;

   vec_normalizer_seq #(.DATAWIDTH(8), .FRAC_BITS(8), .NUM_CH(NCH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_last  (out_last),
      .out_zero  (out_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Offer one vector and wait (bounded) for its accept edge; t_acc = edge count at accept.
   task automatic send(input logic [31:0] v);
      @(negedge clk);
      in_data  = v;
      in_valid = 1'b1;
      snd_to   = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (in_ready) begin
            snd_to = 1'b0;
            break;
         end
         @(negedge clk);
      end
      if (!snd_to) begin
         @(posedge clk);
         #1;
         t_acc = cyc;
      end
      in_valid = 1'b0;
   endtask

   // Capture NCH beats; optionally hold out_ready low stall_len cycles on beat stall_beat.
   task automatic collect(input int stall_beat, input int stall_len);
      int  k, waitc, left;
      bit  seen;
      k = 0; waitc = 0; left = 0; seen = 1'b0;
      cap_unstable = 1'b0; cap_inrdy_bad = 1'b0; cap_timeout = 1'b0;
      while (k < NCH && !cap_timeout) begin
         @(negedge clk);
         if (in_ready) cap_inrdy_bad = 1'b1;
         if (out_valid) begin
            if (!seen) begin
               seen        = 1'b1;
               cap_data[k] = out_data;
               cap_ch[k]   = out_ch;
               cap_last[k] = out_last;
               cap_zero[k] = out_zero;
               cap_rise[k] = cyc;
               left        = (k == stall_beat) ? stall_len : 0;
            end else if (out_data !== cap_data[k] || out_ch !== cap_ch[k] ||
                         out_last !== cap_last[k] || out_zero !== cap_zero[k]) begin
               cap_unstable = 1'b1;
            end
            if (left > 0) begin
               out_ready = 1'b0;
               left--;
            end else begin
               out_ready = 1'b1;
               if (k == NCH - 1) cap_last_hs = cyc + 1;
               k++;
               seen  = 1'b0;
               waitc = 0;
            end
         end else begin
            waitc++;
            if (waitc > 100) cap_timeout = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      ntot++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         nbad++;
         $display("FAIL reset_hs in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
      end
      ntot++;
      if (out_data !== 9'd0 || out_ch !== 2'd0 || out_last !== 1'b0 || out_zero !== 1'b0) begin
         nbad++;
         $display("FAIL reset_out data=%0d ch=%0d last=%b zero=%b required all 0",
                  out_data, out_ch, out_last, out_zero);
      end
      rst = 1'b1;
      @(negedge clk);
      ntot++;
      if (in_ready !== 1'b1) begin
         nbad++;
         $display("FAIL reset_release in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic test_basic();
      logic [8:0] ex [NCH];
`ifdef VEC_NORM_ROUND_EN
      ex[0] = 9'd154; ex[1] = 9'd205;
`else
      ex[0] = 9'd153; ex[1] = 9'd204;
`endif
      ex[2] = 9'd0; ex[3] = 9'd0;
      send(32'h0000_0403);
      ntot++;
      if (snd_to) begin nbad++; $display("FAIL basic_accept timed out"); return; end
      collect(-1, 0);
      ntot++;
      if (cap_timeout) begin nbad++; $display("FAIL basic_beats timed out"); return; end
      for (int k = 0; k < NCH; k++) begin
         ntot++;
         if (cap_data[k] !== ex[k] || cap_ch[k] !== 2'(k) || cap_last[k] !== (k == NCH-1) || cap_zero[k] !== 1'b0) begin
            nbad++;
            $display("FAIL basic_beat%0d data=%0d ch=%0d last=%b zero=%b required %0d %0d %b 0",
                     k, cap_data[k], cap_ch[k], cap_last[k], cap_zero[k], ex[k], k, (k == NCH-1));
         end
      end
      ntot++;
      if (cap_rise[0] - t_acc !== 29) begin
         nbad++;
         $display("FAIL basic_latency got %0d required 29", cap_rise[0] - t_acc);
      end
      for (int k = 1; k < NCH; k++) begin
         ntot++;
         if (cap_rise[k] - cap_rise[k-1] !== 17) begin
            nbad++;
            $display("FAIL basic_gap%0d got %0d required 17", k, cap_rise[k] - cap_rise[k-1]);
         end
      end
   endtask

   task automatic test_full_scale();
      send(32'h0000_00FF);
      ntot++;
      if (snd_to) begin nbad++; $display("FAIL full_accept timed out"); return; end
      collect(-1, 0);
      ntot++;
      if (cap_timeout) begin nbad++; $display("FAIL full_beats timed out"); return; end
      for (int k = 0; k < NCH; k++) begin
         ntot++;
         if (cap_data[k] !== ((k == 0) ? 9'h100 : 9'h000)) begin
            nbad++;
            $display("FAIL full_beat%0d data=%0h required %0h", k, cap_data[k], (k == 0) ? 9'h100 : 9'h000);
         end
      end
   endtask

   task automatic test_zero();
      send(32'h0000_0000);
      ntot++;
      if (snd_to) begin nbad++; $display("FAIL zero_accept timed out"); return; end
      collect(-1, 0);
      ntot++;
      if (cap_timeout) begin nbad++; $display("FAIL zero_beats timed out"); return; end
      for (int k = 0; k < NCH; k++) begin
         ntot++;
         if (cap_data[k] !== 9'd0 || cap_zero[k] !== 1'b1 || cap_ch[k] !== 2'(k) || cap_last[k] !== (k == NCH-1)) begin
            nbad++;
            $display("FAIL zero_beat%0d data=%0d zero=%b ch=%0d last=%b required 0 1 %0d %b",
                     k, cap_data[k], cap_zero[k], cap_ch[k], cap_last[k], k, (k == NCH-1));
         end
      end
      ntot++;
      if (cap_rise[0] - t_acc !== 4) begin
         nbad++;
         $display("FAIL zero_latency got %0d required 4", cap_rise[0] - t_acc);
      end
      ntot++;
      if (cap_rise[3] - cap_rise[0] !== 3) begin
         nbad++;
         $display("FAIL zero_consecutive span got %0d required 3", cap_rise[3] - cap_rise[0]);
      end
   endtask

   task automatic test_stall();
      send(32'h0101_0101);
      ntot++;
      if (snd_to) begin nbad++; $display("FAIL stall_accept timed out"); return; end
      collect(1, 10);
      ntot++;
      if (cap_timeout) begin nbad++; $display("FAIL stall_beats timed out"); return; end
      for (int k = 0; k < NCH; k++) begin
         ntot++;
         if (cap_data[k] !== 9'd128 || cap_ch[k] !== 2'(k)) begin
            nbad++;
            $display("FAIL stall_beat%0d data=%0d ch=%0d required 128 %0d", k, cap_data[k], cap_ch[k], k);
         end
      end
      ntot++;
      if (cap_unstable) begin nbad++; $display("FAIL stall_stable outputs changed while stalled"); end
      ntot++;
      if (cap_rise[2] - cap_rise[1] !== 27) begin
         nbad++;
         $display("FAIL stall_gap got %0d required 27", cap_rise[2] - cap_rise[1]);
      end
      ntot++;
      if (cap_inrdy_bad) begin nbad++; $display("FAIL stall_in_ready high before last beat"); end
      @(negedge clk);
      ntot++;
      if (in_ready !== 1'b1) begin
         nbad++;
         $display("FAIL stall_in_ready_after got %b required 1", in_ready);
      end
   endtask

   task automatic test_reset_mid();
      bit ov_seen;
      send(32'h0000_0403);
      ntot++;
      if (snd_to) begin nbad++; $display("FAIL rmid_accept timed out"); return; end
      repeat (7) @(negedge clk);     // now in SQRT
      rst = 1'b0;
      ov_seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || in_ready !== 1'b0) ov_seen = 1'b1;
      end
      ntot++;
      if (ov_seen) begin nbad++; $display("FAIL rmid_during out_valid/in_ready not 0 in reset"); end
      rst = 1'b1;
      @(negedge clk);
      ntot++;
      if (in_ready !== 1'b1) begin
         nbad++;
         $display("FAIL rmid_in_ready got %b required 1", in_ready);
      end
      ov_seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid !== 1'b0) ov_seen = 1'b1;
      end
      ntot++;
      if (ov_seen) begin nbad++; $display("FAIL rmid_partial out_valid after reset"); end
      test_basic();
   endtask

   task automatic test_back_to_back();
      int  t2;
      bit  to;
      @(negedge clk);
      in_data  = 32'h0000_0403;
      in_valid = 1'b1;
      to = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (in_ready) begin to = 1'b0; break; end
         @(negedge clk);
      end
      ntot++;
      if (to) begin nbad++; $display("FAIL b2b_accept1 timed out"); in_valid = 1'b0; return; end
      @(posedge clk);
      #1;
      t_acc   = cyc;
      in_data = 32'h0000_00FF;
      collect(-1, 0);
      ntot++;
      if (cap_timeout || cap_inrdy_bad) begin
         nbad++;
         $display("FAIL b2b_first timeout=%b early_in_ready=%b required 0 0", cap_timeout, cap_inrdy_bad);
         in_valid = 1'b0;
         return;
      end
      to = 1'b1;
      t2 = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            t2 = cyc;
            to = 1'b0;
            break;
         end
      end
      in_valid = 1'b0;
      ntot++;
      if (to || t2 !== cap_last_hs + 1) begin
         nbad++;
         $display("FAIL b2b_accept2 edge=%0d required %0d", t2, cap_last_hs + 1);
         return;
      end
      collect(-1, 0);
      ntot++;
      if (cap_timeout || cap_data[0] !== 9'h100 || cap_data[1] !== 9'h0) begin
         nbad++;
         $display("FAIL b2b_second timeout=%b beat0=%0h beat1=%0h required 0 100 0",
                  cap_timeout, cap_data[0], cap_data[1]);
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_basic();
      test_full_scale();
      test_zero();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", ntot, nbad);
      $finish;
   end

endmodule
